// File: rtl/dmem_trace_pkg.sv
// Shared types for the data-memory write trace block.
// Holds the word typedefs, the trace entry layout, the FSM encoding and defaults.
package global_types;

  typedef logic [9:0]  logic10;
  typedef logic [15:0] logic16;
  typedef logic [31:0] logic32;

  typedef struct packed {
    logic10 addr;
    logic32 data;
    logic16 cycle;
  } trace_entry_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int     TRACE_DEPTH = 16;
  localparam logic32 HALT_INSTR  = 32'h0800_0015;

endpackage

// File: rtl/dmem_trace_sync_fifo.sv
// First-word-fall-through FIFO with a registered head; the head holds when empty.
// Ports: clk_i/rst_i, push_i/wdata_i, pop_i/rdata_o, full_o/empty_o/count_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    rnext;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = out_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rnext   = rptr_q + 1'b1;

  always_comb begin
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_ok ? rnext : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Head register: the next entry, the incoming word when it becomes
  // the head at once, or the last value when the FIFO drains.
  always_comb begin
    out_d = out_q;
    if (pop_ok) begin
      if (cnt_q == ONE_CNT) begin
        if (push_ok) out_d = wdata_i;
      end else begin
        out_d = mem_q[rnext];
      end
    end else if (empty_o && push_ok) begin
      out_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_trace.sv
// Traces processor data-memory writes into a FIFO until the halt instruction.
// Ports: clock/reset, instruction, dmem_*, rd_* read port, status outputs.
module dmem_trace
  import global_types::*;
#(
  parameter int     DEPTH      = TRACE_DEPTH,
  parameter logic32 HALT_INSTR = global_types::HALT_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            instruction,
  input  logic                   dmem_we,
  input  logic [9:0]             dmem_waddr,
  input  logic [31:0]            dmem_wd,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [9:0]             rd_addr,
  output logic [31:0]            rd_data,
  output logic [15:0]            rd_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted,
  output logic                   done,
  output logic [15:0]            cycle_count
);

  state_e       state_q, state_d;
  logic16       cyc_q, cyc_d;
  logic         ovf_q, ovf_d;
  logic         push, pop;
  logic         f_full, f_empty;
  trace_entry_t w_entry, head;

  assign push    = dmem_we & (state_q == S_RUN);
  assign pop     = rd_ready & ~f_empty;
  assign w_entry = '{addr: dmem_waddr, data: dmem_wd, cycle: cyc_q};

  sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (w_entry),
    .pop_i   (rd_ready),
    .rdata_o (head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (count)
  );

  assign rd_valid    = ~f_empty;
  assign rd_addr     = head.addr;
  assign rd_data     = head.data;
  assign rd_cycle    = head.cycle;
  assign overflow    = ovf_q;
  assign cycle_count = cyc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (instruction == HALT_INSTR) state_d = S_HALTED;
      S_HALTED: if (f_empty) state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    halted = (state_q != S_RUN);
    done   = (state_q == S_DONE);
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_RUN && cyc_q != 16'hFFFF) cyc_d = cyc_q + 1'b1;
  end

  // Only a write that finds no room, even after a same-cycle pop, is lost.
  assign ovf_d = ovf_q | (push & f_full & ~pop);

endmodule

// File: tb/tb_dmem_trace.sv
// Self-checking bench for dmem_trace: vector table, corner sequences, random run.
// A queue-based reference model is compared against every output each cycle.
module tb_dmem_trace;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] HALT = 32'h0800_0015;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   instruction;
  logic          dmem_we;
  logic [9:0]    dmem_waddr;
  logic [31:0]   dmem_wd;
  logic          rd_ready;
  logic          rd_valid;
  logic [9:0]    rd_addr;
  logic [31:0]   rd_data;
  logic [15:0]   rd_cycle;
  logic [CW-1:0] count;
  logic          overflow;
  logic          halted;
  logic          done;
  logic [15:0]   cycle_count;

  dmem_trace #(.DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .dmem_we     (dmem_we),
    .dmem_waddr  (dmem_waddr),
    .dmem_wd     (dmem_wd),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_cycle    (rd_cycle),
    .count       (count),
    .overflow    (overflow),
    .halted      (halted),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [15:0] c;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   m_cyc;
  bit   m_ovf;
  int   m_st;
  int   pushed, popped;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(bit rst, bit we, logic [9:0] a, logic [31:0] d,
                        bit rdy, logic [31:0] ins);
    reset = rst; dmem_we = we; dmem_waddr = a;
    dmem_wd = d; rd_ready = rdy; instruction = ins;
  endtask

  // Reference model: step from the current inputs, clock, compare all outputs.
  task automatic tick();
    bit pp, pu;
    int sz, nst;
    logic [82:0] got, exp;
    if (reset) begin
      q.delete(); last = '0; m_cyc = 0; m_ovf = 0; m_st = 0;
    end else begin
      sz  = q.size();
      pp  = (sz != 0) && rd_ready;
      pu  = dmem_we && (m_st == 0);
      nst = m_st;
      if (m_st == 0 && instruction == HALT) nst = 1;
      else if (m_st == 1 && sz == 0) nst = 2;
      if (pp) begin void'(q.pop_front()); popped++; end
      if (pu) begin
        if (sz < DEPTH || pp) begin
          q.push_back('{dmem_waddr, dmem_wd, m_cyc[15:0]});
          pushed++;
        end else m_ovf = 1;
      end
      if (m_st == 0 && m_cyc < 65535) m_cyc++;
      m_st = nst;
    end
    if (q.size() != 0) last = q[0];
    @(posedge clock); #1;
    got = {rd_valid, rd_addr, rd_data, rd_cycle, count,
           overflow, halted, done, cycle_count};
    exp = {q.size() != 0, last.a, last.d, last.c, CW'(q.size()),
           m_ovf, m_st != 0, m_st == 2, m_cyc[15:0]};
    chk("model", 128'(got), 128'(exp));
  endtask

  typedef struct {
    bit          rst, we;
    logic [9:0]  a;
    logic [31:0] d;
    int          e_cnt;
    bit          e_val;
    logic [9:0]  e_a;
    logic [31:0] e_d;
    logic [15:0] e_c;
    logic [15:0] e_cc;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(bit rst, bit we, logic [9:0] a, logic [31:0] d,
                              int ec, bit ev, logic [9:0] ea,
                              logic [31:0] ed, logic [15:0] ecy,
                              logic [15:0] ecc);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.d = d; v.e_cnt = ec; v.e_val = ev;
    v.e_a = ea; v.e_d = ed; v.e_c = ecy; v.e_cc = ecc;
    return v;
  endfunction

  logic [15:0] cc_save;
  int          n, guard;

  initial begin
    set_in(1, 0, '0, '0, 0, '0);
    pushed = 0; popped = 0;

    // Write capture at cycle stamps 2, 3, 7 with rd_ready held high.
    vt[0] = mk(1, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0);
    vt[1] = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 1);
    vt[2] = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 2);
    vt[3] = mk(0, 1, 10'h1FC, 4, 1, 1, 10'h1FC, 4, 2, 3);
    vt[4] = mk(0, 1, 10'h1F8, 8, 1, 1, 10'h1F8, 8, 3, 4);
    vt[5] = mk(0, 0, 10'h000, 0, 0, 0, 10'h1F8, 8, 3, 5);
    vt[6] = mk(0, 0, 10'h000, 0, 0, 0, 10'h1F8, 8, 3, 6);
    vt[7] = mk(0, 0, 10'h000, 0, 0, 0, 10'h1F8, 8, 3, 7);
    vt[8] = mk(0, 1, 10'h1F4, 3, 1, 1, 10'h1F4, 3, 7, 8);
    vt[9] = mk(0, 0, 10'h000, 0, 0, 0, 10'h1F4, 3, 7, 9);
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].rst, vt[i].we, vt[i].a, vt[i].d, 1, '0);
      tick();
      chk($sformatf("vec%0d", i),
          128'({int'(count), rd_valid, rd_addr, rd_data, rd_cycle,
                cycle_count, overflow, halted, done}),
          128'({vt[i].e_cnt, vt[i].e_val, vt[i].e_a, vt[i].e_d, vt[i].e_c,
                vt[i].e_cc, 3'b000}));
    end

    // Overflow: 17 writes with no reader.
    set_in(1, 0, '0, '0, 0, '0); tick();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 1, 10'h010 + 10'(i), $urandom, 0, '0); tick();
    end
    set_in(0, 0, '0, '0, 0, '0); tick();
    chk("ovf_count", 128'(count), 128'(16));
    chk("ovf_flag", 128'(overflow), 128'(1));
    chk("ovf_head", 128'(rd_addr), 128'(10'h010));

    // Push and pop in the same cycle while full.
    set_in(1, 0, '0, '0, 0, '0); tick();
    for (int i = 0; i < 16; i++) begin
      set_in(0, 1, 10'h020 + 10'(i), $urandom, 0, '0); tick();
    end
    set_in(0, 1, 10'h3FF, 32'hCAFE_F00D, 1, '0); tick();
    chk("full_pp_count", 128'(count), 128'(16));
    chk("full_pp_ovf", 128'(overflow), 128'(0));
    chk("full_pp_head", 128'(rd_addr), 128'(10'h021));
    set_in(0, 0, '0, '0, 1, '0);
    for (int i = 0; i < 15; i++) tick();
    chk("full_pp_tail", 128'({rd_addr, rd_data}), 128'({10'h3FF, 32'hCAFE_F00D}));
    tick();

    // Halt with a same-cycle write, writes ignored afterwards, then drain.
    set_in(1, 0, '0, '0, 0, '0); tick();
    set_in(0, 1, 10'h100, 1, 0, '0); tick();
    set_in(0, 1, 10'h104, 2, 0, '0); tick();
    set_in(0, 1, 10'h108, 3, 0, HALT); tick();
    chk("halt_flag", 128'(halted), 128'(1));
    chk("halt_count", 128'(count), 128'(3));
    cc_save = cycle_count;
    set_in(0, 1, 10'h10C, 4, 0, '0); tick(); tick();
    chk("halt_nopush", 128'(count), 128'(3));
    set_in(0, 1, 10'h10C, 4, 1, '0); tick(); tick(); tick();
    chk("drain_empty", 128'({count, done}), 128'({CW'(0), 1'b0}));
    tick();
    chk("drain_done", 128'(done), 128'(1));
    chk("cc_frozen", 128'(cycle_count), 128'(cc_save));

    // Reset in the middle of a drain after an overflow.
    set_in(1, 0, '0, '0, 0, '0); tick();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 1, 10'(i), $urandom, 0, '0); tick();
    end
    set_in(0, 0, '0, '0, 0, HALT); tick();
    set_in(0, 0, '0, '0, 1, '0); tick(); tick();
    set_in(1, 1, 10'h2AA, 32'h55, 1, HALT); tick();
    chk("rst_mid",
        128'({halted, done, count, rd_valid, overflow, cycle_count, rd_addr}),
        128'({1'b0, 1'b0, CW'(0), 1'b0, 1'b0, 16'h0, 10'h0}));

    // Pointer wrap: 40 writes, at most 5 outstanding.
    set_in(1, 0, '0, '0, 0, '0); tick();
    pushed = 0; popped = 0; n = 0; guard = 0;
    while ((n < 40 || q.size() != 0) && guard < 2000) begin
      bit we;
      we = (n < 40) && (q.size() < 5) && ($urandom_range(0, 3) != 0);
      set_in(0, we, 10'($urandom), $urandom, $urandom_range(0, 2) != 0, '0);
      if (we) n++;
      tick();
      guard++;
    end
    chk("wrap_guard", 128'(guard < 2000), 128'(1));
    chk("wrap_rx", 128'(popped), 128'(40));
    chk("wrap_ovf", 128'(overflow), 128'(0));

    // Random traffic with rare halts and resets.
    set_in(1, 0, '0, '0, 0, '0); tick();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
             10'($urandom), $urandom, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 99) == 0) ? HALT : $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_trace.md
DMEM_TRACE -- requirements
Module: dmem_trace

Interface
REQ-001 Parameter DEPTH, 16, number of trace FIFO entries (power of two, 2..256).
REQ-002 Parameter HALT_INSTR, 32'h0800_0015, instruction word that marks end of program.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instruction  in  32  instruction currently fetched by the processor.
REQ-006 dmem_we  in  1  processor data-memory write enable.
REQ-007 dmem_waddr  in  10  data-memory byte address of the write, i.e. alu_out[9:0].
REQ-008 dmem_wd  in  32  data-memory write data.
REQ-009 rd_ready  in  1  consumer accepts the head entry.
REQ-010 rd_valid  out  1  the head entry is valid.
REQ-011 rd_addr  out  10  head entry address.
REQ-012 rd_data  out  32  head entry write data.
REQ-013 rd_cycle  out  16  head entry cycle stamp.
REQ-014 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 overflow  out  1  sticky flag: at least one write was dropped.
REQ-016 halted  out  1  the halt instruction has been seen.
REQ-017 done  out  1  halted and the FIFO is fully drained.
REQ-018 cycle_count  out  16  cycles elapsed since reset.

Function
REQ-019 cycle_count SHALL increment by 1 each cycle in state RUN.
- It saturates at 16'hFFFF.
- It holds once the block leaves RUN.
REQ-020 A push SHALL occur in any cycle where dmem_we=1 and the state is RUN.
- The entry is {dmem_waddr, dmem_wd, cycle_count}, where cycle_count is the pre-increment value.
REQ-021 A pushed entry SHALL be visible at the read port on the next cycle (latency 1).
- If the FIFO was empty, rd_valid rises on the next cycle.
REQ-022 The read port SHALL be first-word-fall-through.
- rd_valid = (count != 0).
- rd_addr, rd_data and rd_cycle show the head entry.
- A pop occurs when rd_valid && rd_ready.
REQ-023 When rd_valid=0, rd_addr, rd_data and rd_cycle SHALL hold their last values.
- rd_ready is ignored in this case.
REQ-024 Push while full without a pop in the same cycle: the write SHALL be dropped.
- overflow is set and stays set until reset.
- count stays at DEPTH.
REQ-025 Push and pop in the same cycle while full: both SHALL be accepted.
- count is unchanged.
- overflow is not set.
REQ-026 Push and pop in the same cycle at any other non-empty level: count SHALL be unchanged.
- Order is preserved.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH without loss or reordering.
REQ-028 The FSM SHALL have three states: RUN, HALTED and DONE.
- RUN -> HALTED in the cycle after instruction == HALT_INSTR.
- HALTED -> DONE in the cycle after count == 0.
- DONE is terminal until reset.
REQ-029 A write in the same cycle that HALT_INSTR is detected SHALL still be captured.
REQ-030 In HALTED and DONE, dmem_we SHALL be ignored, but pops SHALL continue.
REQ-031 Output decode: halted = (state != RUN); done = (state == DONE).

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL enter RUN and clear all of the following:
- cycle_count = 0
- count = 0
- both pointers = 0
- overflow = 0
- rd_valid = 0
- rd_addr, rd_data and rd_cycle = 0
REQ-033 Reset SHALL take priority over a push, pop or halt detected in the same cycle.
- FIFO contents are discarded.
- An assertion mid-operation loses all entries.

Structure
REQ-034 The shared package global_types SHALL hold the following:
- the logic10, logic16 and logic32 typedefs;
- the packed struct trace_entry_t {addr, data, cycle};
- the constants TRACE_DEPTH and HALT_INSTR.
REQ-035 Storage SHALL live in one sub-module, sync_fifo, parameterised on width and depth.
- It reports full, empty and count.
- dmem_trace holds the FSM, the cycle counter and the overflow flag.

Verification
REQ-036 Write capture:
- Stimulus: reset; 3 writes at cycles 2, 3, 7 (addr 1FC/1F8/1F4, data 4/8/3); rd_ready=1.
- Required: entries pop in order with rd_cycle 2, 3, 7.
REQ-037 Overflow:
- Stimulus: rd_ready=0; 17 consecutive writes (DEPTH=16).
- Required: count=16, overflow=1, head addr equals the first write.
REQ-038 Push and pop while full:
- Stimulus: FIFO full; one cycle with a write and rd_ready=1.
- Required: count stays 16, overflow stays 0, new entry is at the tail.
REQ-039 Halt and drain:
- Stimulus: instruction=32'h0800_0015 with a write in the same cycle, 2 entries already queued; then rd_ready=1.
- Required: halted=1 next cycle; 3 entries drain; done=1 the cycle after count=0; cycle_count frozen.
REQ-040 Writes after halt and reset mid-drain:
- Stimulus: dmem_we=1 after halted; later reset=1 mid-drain.
- Required: no push after halt; after reset, state RUN, count=0, rd_valid=0, overflow=0.
REQ-041 Pointer wrap:
- Stimulus: 40 writes interleaved with pops, never more than 5 entries outstanding.
- Required: all 40 entries received in order, overflow=0.
